// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - sequential square matrix multiply controller (C = A x B) over external memories
module matmul_ctrl #(
  parameter int row    = 2,
  parameter int column = 2,
  parameter int size   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            a_read,
  output logic            b_read,
  output logic [5:0]      a_addr,
  output logic [5:0]      b_addr,
  input  logic [size-1:0] a_data,
  input  logic [size-1:0] b_data,
  output logic            c_write,
  output logic [5:0]      c_addr,
  output logic [size-1:0] c_value,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  localparam int IW = (row > 1) ? $clog2(row) : 1;
  localparam int AW = 2 * size + 3;
  // matrices are square, so one terminal index value serves i, j and k
  localparam logic [IW-1:0] LAST = IW'(column - 1);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t        state;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] k;
  logic [AW-1:0] acc;
  logic [AW-1:0] prod;

  // linear element address (r, c) -> row*r + c
  function automatic logic [5:0] lin(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return 6'(row) * 6'(r) + 6'(c);
  endfunction

  assign prod = AW'(a_data) * AW'(b_data);

  // control FSM: indices, accumulator and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= MAC;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            overflow <= 1'b0;
          end
        end
        MAC: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            acc <= acc + prod;
            if (k == LAST) begin
              k     <= '0;
              state <= WRITE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        WRITE: begin
          // the write of this cycle happens even when aborted, so its overflow counts too
          if (|acc[AW-1:size]) overflow <= 1'b1;
          acc <= '0;
          if (abort) begin
            state <= IDLE;
          end else if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i     <= '0;
              state <= DONE;
            end else begin
              i     <= i + 1'b1;
              state <= MAC;
            end
          end else begin
            j     <= j + 1'b1;
            state <= MAC;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // memory strobes and status decoded purely from registered state
  always_comb begin
    a_read  = 1'b0;
    b_read  = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    c_write = 1'b0;
    c_addr  = '0;
    c_value = '0;
    case (state)
      MAC: begin
        a_read = 1'b1;
        b_read = 1'b1;
        a_addr = lin(i, k);
        b_addr = lin(k, j);
      end
      WRITE: begin
        c_write = 1'b1;
        c_addr  = lin(i, j);
        c_value = acc[size-1:0];
      end
      default: ;
    endcase
    busy = (state == MAC) || (state == WRITE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - randomized and directed self-checking bench for matmul_ctrl
module tb_matmul_ctrl;

  localparam int N = 2;
  localparam int L = N * N * (N + 1);

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       a_read, b_read, c_write, busy, done, overflow;
  logic [5:0] a_addr, b_addr, c_addr;
  logic [7:0] a_data, b_data, c_value;

  logic [7:0] a_mem [64];
  logic [7:0] b_mem [64];

  int checks   = 0;
  int failures = 0;

  matmul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_read(a_read), .b_read(b_read), .a_addr(a_addr), .b_addr(b_addr),
    .a_data(a_data), .b_data(b_data),
    .c_write(c_write), .c_addr(c_addr), .c_value(c_value),
    .busy(busy), .done(done), .overflow(overflow)
  );

  assign a_data = a_mem[a_addr];
  assign b_data = b_mem[b_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3;
    b_mem[0] = b0; b_mem[1] = b1; b_mem[2] = b2; b_mem[3] = b3;
  endtask

  // one multiply: ab = cycle in which abort is raised (>L means never),
  // restart_mask bit n raises start again in cycle n
  task automatic run_mul(input int ab, input logic [31:0] restart_mask);
    logic [31:0] cfull [N*N];
    int ovf_run;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        cfull[r*N+c] = 0;
        for (int m = 0; m < N; m++)
          cfull[r*N+c] += a_mem[r*N+m] * b_mem[m*N+c];
      end
    ovf_run = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= L + 2; cyc++) begin
      int live, e, ph, wr, rd;
      live = (cyc <= L) && (cyc <= ab);
      e    = (cyc - 1) / (N + 1);
      ph   = (cyc - 1) % (N + 1);
      wr   = live && (ph == N);
      rd   = live && (ph < N);
      chk("busy", busy, live);
      chk("done", done, (ab > L) && (cyc == L + 1));
      chk("a_read", a_read, rd);
      chk("b_read", b_read, rd);
      chk("a_addr", a_addr, rd ? N * (e / N) + ph : 0);
      chk("b_addr", b_addr, rd ? N * ph + (e % N) : 0);
      chk("c_write", c_write, wr);
      chk("c_addr", c_addr, wr ? e : 0);
      if (wr) chk("c_value", c_value, cfull[e] % 256);
      chk("overflow", overflow, ovf_run);
      if (wr && cfull[e] > 255) ovf_run = 1;
      start = (cyc < 32) ? restart_mask[cyc] : 1'b0;
      abort = (cyc == ab);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
    chk("overflow_end", overflow, ovf_run);
  endtask

  initial begin
    int ab, lim;
    logic [31:0] mask;
    for (int n = 0; n < 64; n++) begin a_mem[n] = 0; b_mem[n] = 0; end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cwrite", c_write, 0);
    chk("rst_aread", a_read, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // basic product
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run_mul(1000, 0);
    // saturating inputs set overflow, the next start clears it
    load(255, 255, 255, 255, 255, 255, 255, 255);
    run_mul(1000, 0);
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run_mul(1000, 0);
    // identity, start re-pulsed while busy and in DONE
    load(1, 0, 0, 1, 9, 8, 7, 6);
    run_mul(1000, (1 << 3) | (1 << 7) | (1 << 13));
    // abort during MAC of element 1, then a clean run
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run_mul(5, 0);
    run_mul(1000, 0);

    // abort together with start in IDLE: stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_aread", a_read, 0);
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of the first WRITE
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_cwrite", c_write, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_cwrite", c_write, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cwrite", c_write, 0);
    end
    run_mul(1000, 0);

    // randomized matrices, aborts and ignored restarts
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < N * N; n++) begin
        a_mem[n] = 8'($urandom);
        b_mem[n] = 8'($urandom);
      end
      ab   = ($urandom_range(0, 1) == 0) ? 1000 : int'($urandom_range(1, L));
      lim  = (ab <= L) ? ab : L + 1;
      mask = $urandom & ((32'd1 << (lim + 1)) - 1) & ~32'd1;
      run_mul(ab, mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter: row, 2, number of matrix rows.
REQ-002 Parameter: column, 2, number of matrix columns; SHALL equal row; row*column SHALL be at most 64.
REQ-003 Parameter: size, 8, element width in bits for A, B and C.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one multiply C = A x B; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a running multiply.
REQ-008 a_read, b_read  output  1 each  read enables to the A and B memories.
REQ-009 a_addr, b_addr  output  6 each  read addresses, element (i,j) at row*i+j.
REQ-010 a_data, b_data  input  size each  asynchronous read data from the A and B memories.
REQ-011 c_write  output  1  write enable to the C memory.
REQ-012 c_addr  output  6  C write address.
REQ-013 c_value  output  size  C write data.
REQ-014 busy  output  1  high in MAC and WRITE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 overflow  output  1  sticky flag: some C element exceeded 2^size-1.

Function
REQ-017 FSM states SHALL be IDLE, MAC, WRITE and DONE, with indices i, j, k and an accumulator acc of width 2*size+3.
REQ-018 IDLE: start=1 -> MAC with i=j=k=0, acc=0 and overflow cleared; start=0 -> stay in IDLE.
REQ-019 MAC: a_read=b_read=1, a_addr=row*i+k, b_addr=row*k+j, and acc <= acc + a_data*b_data (unsigned, full width) each cycle.
REQ-020 MAC: k<column-1 -> k+1, stay in MAC; k=column-1 -> WRITE with k=0.
REQ-021 WRITE: c_write=1, c_addr=row*i+j, c_value=acc[size-1:0] (truncated) for exactly one cycle.
REQ-022 WRITE: acc > 2^size-1 -> overflow <= 1 (sticky until the next accepted start).
REQ-023 WRITE: acc <= 0; j<column-1 -> j+1; else j=0 and i+1; last element (i=row-1, j=column-1) -> DONE, else -> MAC.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 Write order SHALL be row-major: C addresses 0,1,...,row*column-1.
REQ-026 Latency: accepted start to done high = row*column*(column+1) cycles; done is in cycle 13 for the 2x2 default.
REQ-027 a_read, b_read and c_write SHALL be 0 in all states not listed above; a_addr, b_addr and c_addr SHALL be 0 when not in use.
REQ-028 start while busy or in DONE SHALL be ignored, with no restart and no queuing.
REQ-029 abort=1 in MAC or WRITE -> IDLE next cycle, no further writes, done not pulsed; a WRITE-cycle write in the abort cycle still occurs.
REQ-030 abort in IDLE SHALL be ignored; abort and start together in IDLE -> abort wins, stay in IDLE.
REQ-031 busy SHALL be a registered state decode, with no combinational path from start.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, i=j=k=0, acc=0, busy=0, done=0, overflow=0 and all read/write enables 0, regardless of clk.
REQ-033 rst asserted mid-operation SHALL abandon the multiply with no further C writes; leaving reset resumes in IDLE and waits for start.

Verification
REQ-034 A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> C writes addr0=19, addr1=22, addr2=43, addr3=50 in order; done in cycle 13; overflow=0.
REQ-035 A=B=all 255 -> every c_value=2 (130050 mod 256); overflow=1 after first WRITE and held after done; next start clears it.
REQ-036 A=[[1,0],[0,1]], B=[[9,8],[7,6]] -> C=[[9,8],[7,6]]; start re-pulsed in cycles 3 and 7 -> no effect, same write sequence and timing.
REQ-037 abort in cycle 5 (MAC of element 1) -> only addr0 written, busy low next cycle, done never pulses; a fresh start then yields full correct C.
REQ-038 rst=0 asynchronously mid-WRITE -> c_write, busy and done drop immediately without a clk edge; after release, IDLE until start.
